// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
// Pure declarations: no latency, no flow control.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF  = 8;
  localparam int PWM_NUM_CH_DEF = 4;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef logic [PWM_WIDTH_DEF-1:0] duty_t;

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: shadow duty register, active duty register, registered compare.
// Latency: 1 cycle from counter value to pwm. Backpressure: pend stays set until the next load.
import pwm_pkg::*;

module pwm_ch_cmp #(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic             clk_pwm,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic             wr_acc,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pend,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic [WIDTH-1:0] duty_act_q,  duty_act_d;
  logic             pend_q,      pend_d;
  logic             pwm_q,       pwm_d;

  always_comb begin
    duty_pend_d = duty_pend_q;
    duty_act_d  = duty_act_q;
    pend_d      = pend_q;
    if (load && pend_q) begin
      duty_act_d = duty_pend_q;
      pend_d     = 1'b0;
    end
    // A write landing on a load cycle bypasses the shadow register.
    if (wr_acc) begin
      if (load) begin
        duty_act_d = wr_duty;
      end else begin
        duty_pend_d = wr_duty;
        pend_d      = 1'b1;
      end
    end
    pwm_d = run & (cnt < duty_act_q);
  end

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) begin
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      pend_q      <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      pend_q      <= pend_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pend = pend_q;
  assign pwm  = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// NUM_CH PWM outputs on a shared period counter; PWM_CENTER_ALIGN_EN selects up/down counting.
// Latency: outputs registered, 1 cycle behind the counter. Backpressure: wr_ready=0 while the target channel has a pending duty.
import pwm_pkg::*;

module pwm_multi_gen #(
  parameter int NUM_CH = PWM_NUM_CH_DEF,
  parameter int WIDTH  = PWM_WIDTH_DEF
) (
  input  logic                          clk_pwm,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [WIDTH-1:0]              period,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]              wr_duty,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          period_tick
);

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  period_act_q, period_act_d;
  logic              tick_q, tick_d;
  logic              run, wrap, load;
  logic              wr_rdy;
  logic [NUM_CH-1:0] wr_acc;
  logic [NUM_CH-1:0] pend;

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_q, dir_d;  // 1 = counting down

  // A zero period parks the counter and keeps reloading, like en=0.
  assign run  = en & (period_act_q != '0);
  assign wrap = run & dir_q & (cnt_q == '0);
`else
  assign run  = en;
  assign wrap = en & (cnt_q == period_act_q);
`endif
  assign load = ~run | wrap;

  always_comb begin
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    tick_d       = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d        = dir_q;
`endif
    if (!run || wrap) begin
      cnt_d        = '0;
      period_act_d = period;
      tick_d       = wrap;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d        = 1'b0;
`endif
    end else begin
`ifdef PWM_CENTER_ALIGN_EN
      // Both turnarounds hold the count one cycle, so a period is 2*period_act.
      if (!dir_q) begin
        if (cnt_q == period_act_q - WIDTH'(1)) dir_d = 1'b1;
        else                                   cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
`else
      cnt_d = cnt_q + WIDTH'(1);
`endif
    end
  end

  always_comb begin
    wr_rdy = 1'b0;
    wr_acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(wr_ch) == i) wr_rdy = ~pend[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wr_acc[i] = wr_valid & wr_rdy & (int'(wr_ch) == i);
    end
  end

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      period_act_q <= '0;
      tick_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      tick_q       <= tick_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= dir_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_ch_cmp #(.WIDTH(WIDTH)) u_ch (
      .clk_pwm (clk_pwm),
      .rst_n   (rst_n),
      .run     (run),
      .load    (load),
      .wr_acc  (wr_acc[g]),
      .wr_duty (wr_duty),
      .cnt     (cnt_q),
      .pend    (pend[g]),
      .pwm     (pwm_out[g])
    );
  end

  assign wr_ready    = wr_rdy;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: vector table of steady-state duty/period cases plus
// hand sequences for shadow updates, wrap-cycle writes, stalls and mid-run reset.
module tb_pwm_multi_gen;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;

  logic              clk_pwm = 1'b0;
  logic              rst_n;
  logic              en;
  logic [WIDTH-1:0]  period;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_ch;
  logic [WIDTH-1:0]  wr_duty;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;

  int n_total = 0;
  int n_pass  = 0;

  pwm_multi_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk_pwm     (clk_pwm),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk_pwm = ~clk_pwm;

  typedef struct {
    logic [7:0] per;
    logic [7:0] duty;
    int         win;
    int         exp_hi;
    int         exp_tk;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge: loads a duty with en low (takes effect at once), then raises en.
  task automatic setup(input logic [7:0] p, input logic [1:0] ch, input logic [7:0] d);
    en = 1'b0; period = p;
    wr_valid = 1'b1; wr_ch = ch; wr_duty = d;
    @(negedge clk_pwm);
    wr_valid = 1'b0;
    @(negedge clk_pwm);
    en = 1'b1;
  endtask

  initial begin
    int hi, tk, oth;
    int hp[4];
    int bad;
    logic pat[8];

    vecs[0] = '{per: 8'd9,   duty: 8'd3,   win: 20,  exp_hi: 6,   exp_tk: 2};
    vecs[1] = '{per: 8'd9,   duty: 8'd0,   win: 20,  exp_hi: 0,   exp_tk: 2};
    vecs[2] = '{per: 8'd9,   duty: 8'd10,  win: 20,  exp_hi: 20,  exp_tk: 2};
    vecs[3] = '{per: 8'd255, duty: 8'd255, win: 256, exp_hi: 255, exp_tk: 1};
    vecs[4] = '{per: 8'd4,   duty: 8'd2,   win: 15,  exp_hi: 6,   exp_tk: 3};
    vecs[5] = '{per: 8'd0,   duty: 8'd1,   win: 5,   exp_hi: 5,   exp_tk: 5};
    vecs[6] = '{per: 8'd3,   duty: 8'd3,   win: 8,   exp_hi: 6,   exp_tk: 2};

    rst_n = 1'b0; en = 1'b0; period = '0;
    wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;
    repeat (2) @(negedge clk_pwm);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    @(negedge clk_pwm);
    chk("rst_rdy", int'(wr_ready), 1);

`ifdef PWM_CENTER_ALIGN_EN
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    setup(8'd4, 2'd0, 8'd2);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_pwm);
      chk($sformatf("ctr_pwm_%0d", j), int'(pwm_out[0]), int'(pat[(j-1)%8]));
      chk($sformatf("ctr_tick_%0d", j), int'(period_tick), ((j % 8) == 0) ? 1 : 0);
    end
`else
    foreach (vecs[v]) begin
      setup(vecs[v].per, 2'd0, vecs[v].duty);
      hi = 0; tk = 0; oth = 0;
      for (int j = 0; j < vecs[v].win; j++) begin
        @(negedge clk_pwm);
        hi  += int'(pwm_out[0]);
        tk  += int'(period_tick);
        oth += int'(pwm_out[2:1] != 2'b00);
      end
      chk($sformatf("vec%0d_high", v), hi, vecs[v].exp_hi);
      chk($sformatf("vec%0d_tick", v), tk, vecs[v].exp_tk);
      chk($sformatf("vec%0d_other", v), oth, 0);
    end

    // Mid-period duty change on ch1 waits for the wrap.
    setup(8'd9, 2'd1, 8'd8);
    hp = '{0, 0, 0, 0};
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_pwm);
      hp[(j-1)/10] += int'(pwm_out[1]);
      if (j == 3)  begin wr_valid = 1'b1; wr_duty = 8'd2; end
      if (j == 4)  begin chk("mid_rdy_after_acc", int'(wr_ready), 0); wr_valid = 1'b0; end
      if (j == 9)  chk("mid_rdy_before_wrap", int'(wr_ready), 0);
      if (j == 10) chk("mid_rdy_after_wrap", int'(wr_ready), 1);
    end
    chk("mid_p1_high", hp[0], 8);
    chk("mid_p2_high", hp[1], 2);

    // Write on the wrap cycle, then a stalled second write.
    setup(8'd9, 2'd2, 8'd0);
    hp = '{0, 0, 0, 0};
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_pwm);
      hp[(j-1)/10] += int'(pwm_out[2]);
      if (j == 9)  begin wr_valid = 1'b1; wr_duty = 8'd5; end
      if (j == 10) begin chk("wrap_rdy_no_pend", int'(wr_ready), 1); wr_valid = 1'b0; end
      if (j == 12) begin wr_valid = 1'b1; wr_duty = 8'd7; end
      if (j == 13) begin chk("stall_rdy_13", int'(wr_ready), 0); wr_duty = 8'd1; end
      if (j == 19) chk("stall_rdy_19", int'(wr_ready), 0);
      if (j == 20) chk("stall_rdy_20", int'(wr_ready), 1);
      if (j == 21) wr_valid = 1'b0;
    end
    chk("wrap_p1_high", hp[0], 0);
    chk("wrap_p2_high", hp[1], 5);
    chk("wrap_p3_high", hp[2], 7);
    chk("wrap_p4_high", hp[3], 1);
`endif

    // Reset in the middle of a running period with a write pending.
    setup(8'd9, 2'd0, 8'd10);
    repeat (5) @(negedge clk_pwm);
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    wr_ch = 2'd1; wr_duty = 8'd4; wr_valid = 1'b1;
    @(negedge clk_pwm);
    chk("pre_rst_rdy", int'(wr_ready), 0);
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_tick", int'(period_tick), 0);
    @(negedge clk_pwm);
    rst_n = 1'b1;
    chk("post_rst_rdy", int'(wr_ready), 1);
    bad = 0;
    repeat (12) begin
      @(negedge clk_pwm);
      bad += int'(pwm_out != '0);
    end
    chk("post_rst_pwm_low", bad, 0);

    wr_ch = 2'd3;
    #1;
    chk("bad_ch_rdy", int'(wr_ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
